local_memory_arbiter: RTL

Shares one single-port SRAM macro between three requesters: core instruction fetch (port 0), core data (port 1), and the wishbone SRAM interface's local-memory port (port 2). Sits between those requesters and the OpenRAM-style macro. Each requester sees the enable/busy local-memory protocol. The macro sees registered, active-low chip and write selects.

---
 rtl/local_memory_arbiter_pkg.sv | 19 +
 rtl/round_robin_select.sv | 26 ++
 rtl/local_memory_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/local_memory_arbiter_pkg.sv
// Shared types and helpers for the three-port local-memory SRAM arbiter.
package local_memory_arbiter_pkg;
   localparam int NUM_PORTS = 3;

   localparam logic [1:0] PORT_INSTR = 2'd0;
   localparam logic [1:0] PORT_DATA  = 2'd1;
   localparam logic [1:0] PORT_WB    = 2'd2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      READ_WAIT = 2'd2
   } state_e;

   // Next port index in round-robin order, wrapping 2 -> 0.
   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p >= PORT_WB) ? PORT_INSTR : p + 2'd1;
   endfunction
endpackage

// File: rtl/round_robin_select.sv
// Combinational round-robin pick among three requesters, search starting after last.
module round_robin_select
   import local_memory_arbiter_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [1:0]           last_i,
   output logic [1:0]           winner_o,
   output logic                 valid_o
);
   logic [1:0] cand;
   logic       found;

   always_comb begin
      winner_o = PORT_INSTR;
      found    = 1'b0;
      cand     = rr_next(last_i);
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!found && req_i[cand]) begin
            winner_o = cand;
            found    = 1'b1;
         end
         cand = rr_next(cand);
      end
      valid_o = found;
   end
endmodule

// File: rtl/local_memory_arbiter.sv
// Arbitrates three enable/busy requesters onto one single-port OpenRAM-style SRAM.
module local_memory_arbiter
   import local_memory_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [2:0]            req_enable,
   input  logic [2:0]            req_writeEnable,
   input  logic [11:0]           req_byteSelect,
   input  logic [71:0]           req_address,
   input  logic [95:0]           req_dataWrite,
   output logic [95:0]           req_dataRead,
   output logic [2:0]            req_busy,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [3:0]            sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [31:0]           sram_din0,
   input  logic [31:0]           sram_dout0
);
   state_e                state_q, state_d;
   logic [1:0]            last_q, last_d, win_q, win_d;
   logic                  we_q, we_d;
   logic [3:0]            sel_q, sel_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           data_q, data_d;

   logic [1:0]            rr_win;
   logic                  rr_vld;
   logic [NUM_PORTS-1:0]  cmpl, rd_done;

   logic [3:0]            sel_a  [NUM_PORTS];
   logic [ADDR_WIDTH-1:0] addr_a [NUM_PORTS];
   logic [31:0]           data_a [NUM_PORTS];
   logic                  unused_addr;

   // Region decode happens upstream; only the word-address bits matter here.
   assign unused_addr = ^req_address;

   round_robin_select u_rr (
      .req_i    (req_enable),
      .last_i   (last_q),
      .winner_o (rr_win),
      .valid_o  (rr_vld)
   );

   for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
      assign sel_a[n]  = req_byteSelect[4*n +: 4];
      assign addr_a[n] = req_address[24*n+2 +: ADDR_WIDTH];
      assign data_a[n] = req_dataWrite[32*n +: 32];
      // A port that dropped enable sees no completion and keeps all-ones read data.
      assign req_busy[n]              = req_enable[n] & ~cmpl[n];
      assign req_dataRead[32*n +: 32] = (rd_done[n] & req_enable[n]) ? sram_dout0 : '1;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         last_q  <= PORT_WB;
         win_q   <= PORT_INSTR;
         we_q    <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      win_d   = win_q;
      we_d    = we_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: if (rr_vld) begin
            win_d   = rr_win;
            we_d    = req_writeEnable[rr_win];
            sel_d   = sel_a[rr_win];
            addr_d  = addr_a[rr_win];
            data_d  = data_a[rr_win];
            state_d = ISSUE;
         end
         ISSUE: begin
            last_d  = win_q;
            state_d = we_q ? IDLE : READ_WAIT;
         end
         READ_WAIT: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = '0;
      sram_din0   = '0;
      cmpl        = '0;
      rd_done     = '0;
      case (state_q)
         ISSUE: begin
            sram_csb0   = 1'b0;
            sram_web0   = ~we_q;
            sram_wmask0 = we_q ? sel_q : 4'h0;
            sram_addr0  = addr_q;
            sram_din0   = data_q;
            cmpl[win_q] = we_q;
         end
         READ_WAIT: begin
            cmpl[win_q]    = 1'b1;
            rd_done[win_q] = 1'b1;
         end
         default: ;
      endcase
   end
endmodule
